// File: rtl/regs_mp.sv
// regs_mp -- multi-read-port register file with a per-register busy scoreboard.
//
// Register 0 is hard-wired to zero. Two write ports (w1 has priority over w0)
// update the array on the rising edge of clk. An issue request marks its
// destination register busy; a write to that register clears the mark, and an
// issue wins over a write that lands on the same register in the same cycle.
// busy_cnt_o is a registered population count of the busy vector.
//
// Optional feature: define REGS_MP_BYPASS_EN to forward same-cycle write data
// (w1 first, then w0) onto the read ports, and to show a register that is being
// written this cycle as not busy unless it is also being issued this cycle.
// Without the macro, reads show only the registered array and busy state.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-low reset; also forces read outputs to zero
//   rd_addr_i   NRD read addresses, port k at [k*AW +: AW]
//   rd_data_o   NRD read data words, port k at [k*XLEN +: XLEN]
//   rd_busy_o   busy flag of each read address
//   w0_*        write port 0 (lower priority)
//   w1_*        write port 1 (higher priority)
//   iss_*       issue request, marks iss_addr_i busy
//   busy_cnt_o  number of busy registers
module regs_mp #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic                w0_en_i,
    input  logic [AW-1:0]       w0_addr_i,
    input  logic [XLEN-1:0]     w0_data_i,
    input  logic                w1_en_i,
    input  logic [AW-1:0]       w1_addr_i,
    input  logic [XLEN-1:0]     w1_data_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i,
    output logic [AW:0]         busy_cnt_o
);

    localparam int NREG = 2 ** AW;

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     cnt_d;

    // Clear on write first, then set on issue, so an issue always wins.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREG; i++) begin
            if (w0_en_i && (w0_addr_i == AW'(i))) busy_d[i] = 1'b0;
            if (w1_en_i && (w1_addr_i == AW'(i))) busy_d[i] = 1'b0;
            if (iss_en_i && (iss_addr_i == AW'(i))) busy_d[i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // The count is taken from the next busy vector so it matches busy_q after the edge.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_o <= '0;
        end else begin
            // w1 is assigned last so it overrides w0 on an address collision.
            if (w0_en_i && (w0_addr_i != '0)) mem[w0_addr_i] <= w0_data_i;
            if (w1_en_i && (w1_addr_i != '0)) mem[w1_addr_i] <= w1_data_i;
            busy_q     <= busy_d;
            busy_cnt_o <= cnt_d;
        end
    end

    logic [AW-1:0] ra;
`ifdef REGS_MP_BYPASS_EN
    logic hit0;
    logic hit1;
    logic hit_iss;
`endif

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        ra        = '0;
`ifdef REGS_MP_BYPASS_EN
        hit0      = 1'b0;
        hit1      = 1'b0;
        hit_iss   = 1'b0;
`endif
        for (int k = 0; k < NRD; k++) begin
            ra = rd_addr_i[k*AW +: AW];
            if (rst && (ra != '0)) begin
                rd_data_o[k*XLEN +: XLEN] = mem[ra];
                rd_busy_o[k]              = busy_q[ra];
`ifdef REGS_MP_BYPASS_EN
                hit0    = w0_en_i && (w0_addr_i == ra);
                hit1    = w1_en_i && (w1_addr_i == ra);
                hit_iss = iss_en_i && (iss_addr_i == ra);
                if (hit1) begin
                    rd_data_o[k*XLEN +: XLEN] = w1_data_i;
                end else if (hit0) begin
                    rd_data_o[k*XLEN +: XLEN] = w0_data_i;
                end
                if ((hit0 || hit1) && !hit_iss) rd_busy_o[k] = 1'b0;
`endif
            end
        end
    end

endmodule
